// File: rtl/forward.sv
// Sequential MLP inference engine. One multiply-accumulate per cycle walks
// every layer, applies a saturating ReLU, and leaves the packed per-layer
// activations plus the network output on registered ports.

package forward_pkg;
    // Upper bound on topology fields the offset helpers can walk.
    localparam int LS_CAP = 32;
    localparam int LS_W   = 16 * (LS_CAP + 1);

    // Width of activation layer k.
    function automatic int ls_field(input logic [LS_W-1:0] ls, input int k);
        return int'(ls[k*16 +: 16]);
    endfunction

    // Word offset of layer l inside the packed weight vector.
    function automatic int w_off(input logic [LS_W-1:0] ls, input int l);
        int s;
        s = 0;
        for (int m = 0; m < LS_CAP; m++)
            if (m < l) s += ls_field(ls, m) * ls_field(ls, m + 1);
        return s;
    endfunction

    // Word offset of layer l inside the packed bias vector.
    function automatic int b_off(input logic [LS_W-1:0] ls, input int l);
        int s;
        s = 0;
        for (int m = 0; m < LS_CAP; m++)
            if (m < l) s += ls_field(ls, m + 1);
        return s;
    endfunction

    // Word offset of activation layer k inside the packed activation vector.
    function automatic int a_off(input logic [LS_W-1:0] ls, input int k);
        int s;
        s = 0;
        for (int m = 0; m < LS_CAP + 1; m++)
            if (m < k) s += ls_field(ls, m);
        return s;
    endfunction
endpackage

module forward
    import forward_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int NUM_LAYERS = 2,
    parameter logic [(MAX_LAYERS+1)*16-1:0] LAYER_SIZES =
        {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd3, 16'd2},
    localparam logic [LS_W-1:0] LS_EXT = LS_W'(LAYER_SIZES),
    localparam int L0            = ls_field(LS_EXT, 0),
    localparam int L_OUT         = ls_field(LS_EXT, NUM_LAYERS),
    localparam int TOTAL_WEIGHTS = w_off(LS_EXT, NUM_LAYERS),
    localparam int TOTAL_BIASES  = b_off(LS_EXT, NUM_LAYERS),
    localparam int TOTAL_ACTS    = a_off(LS_EXT, NUM_LAYERS + 1),
    localparam int AO_OUT        = a_off(LS_EXT, NUM_LAYERS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [L0*16-1:0]            x,
    input  logic [TOTAL_WEIGHTS*16-1:0] w,
    input  logic [TOTAL_BIASES*16-1:0]  b,
    output logic [TOTAL_ACTS*16-1:0]    activations,
    output logic [L_OUT*16-1:0]         y,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT_LAYER = 3'd1,
        MAC        = 3'd2,
        STORE      = 3'd3,
        NEXT_LAYER = 3'd4,
        DONE_STATE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [31:0] layer_q, layer_d;
    logic [31:0] i_q, i_d, j_q, j_d;
    logic [31:0] n_in_q, n_in_d, n_out_q, n_out_d;
    logic [31:0] wo_q, wo_d, bo_q, bo_d, ai_q, ai_d, ao_q, ao_d;
    logic signed [31:0] acc_q, acc_d;
    logic [TOTAL_ACTS*16-1:0] acts_q, acts_d;
    logic [L_OUT*16-1:0] y_q, y_d;
    logic busy_q, busy_d, done_q, done_d;

    logic [31:0] w_idx, a_idx, bn_idx, o_idx;
    logic [31:0] wo_now, bo_now, ai_now, ao_now, nin_now, nout_now;
    logic [15:0] w_word, a_word, bn_word, b0_word;
    logic signed [31:0] w_ext, a_ext, prod;

    // Shift accumulator down by the Q8.8 fraction, clamp negatives to zero and
    // saturate anything above the Q8.8 maximum.
    function automatic logic [15:0] relu_sat(input logic signed [31:0] a);
        logic signed [31:0] s;
        s = a >>> 8;
        if (s <= 0)
            return 16'h0000;
        else if (s > 32'sd32767)
            return 16'h7FFF;
        else
            return s[15:0];
    endfunction

    // Bias aligned to the Q16.16 accumulator scale.
    function automatic logic signed [31:0] bias_acc(input logic [15:0] bw);
        return {{8{bw[15]}}, bw, 8'h00};
    endfunction

    // Operand fetch: word indices for the current MAC term, the next bias and
    // the output slot, plus the per-layer geometry for the layer being entered.
    always_comb begin
        w_idx    = wo_q + i_q * n_in_q + j_q;
        a_idx    = ai_q + j_q;
        bn_idx   = bo_q + i_q + 32'd1;
        o_idx    = ao_q + i_q;
        wo_now   = 32'(w_off(LS_EXT, int'(layer_q)));
        bo_now   = 32'(b_off(LS_EXT, int'(layer_q)));
        ai_now   = 32'(a_off(LS_EXT, int'(layer_q)));
        ao_now   = 32'(a_off(LS_EXT, int'(layer_q) + 1));
        nin_now  = 32'(ls_field(LS_EXT, int'(layer_q)));
        nout_now = 32'(ls_field(LS_EXT, int'(layer_q) + 1));
        w_word   = w[w_idx*16 +: 16];
        a_word   = acts_q[a_idx*16 +: 16];
        bn_word  = b[bn_idx*16 +: 16];
        b0_word  = b[bo_now*16 +: 16];
        w_ext    = {{16{w_word[15]}}, w_word};
        a_ext    = {{16{a_word[15]}}, a_word};
        prod     = w_ext * a_ext;
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            layer_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            n_in_q  <= '0;
            n_out_q <= '0;
            wo_q    <= '0;
            bo_q    <= '0;
            ai_q    <= '0;
            ao_q    <= '0;
            acc_q   <= '0;
            acts_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            i_q     <= i_d;
            j_q     <= j_d;
            n_in_q  <= n_in_d;
            n_out_q <= n_out_d;
            wo_q    <= wo_d;
            bo_q    <= bo_d;
            ai_q    <= ai_d;
            ao_q    <= ao_d;
            acc_q   <= acc_d;
            acts_q  <= acts_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state sequencing through layers, neurons and MAC terms.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = INIT_LAYER;
            INIT_LAYER: state_d = MAC;
            MAC:        if (j_q == n_in_q - 32'd1) state_d = STORE;
            STORE:      state_d = (i_q == n_out_q - 32'd1) ? NEXT_LAYER : MAC;
            NEXT_LAYER: state_d = (layer_q == 32'(NUM_LAYERS - 1)) ? DONE_STATE
                                                                  : INIT_LAYER;
            DONE_STATE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath and status updates for each state.
    always_comb begin
        layer_d = layer_q;
        i_d     = i_q;
        j_d     = j_q;
        n_in_d  = n_in_q;
        n_out_d = n_out_q;
        wo_d    = wo_q;
        bo_d    = bo_q;
        ai_d    = ai_q;
        ao_d    = ao_q;
        acc_d   = acc_q;
        acts_d  = acts_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    acts_d[L0*16-1:0] = x;
                    layer_d           = '0;
                    busy_d            = 1'b1;
                end
            end
            INIT_LAYER: begin
                n_in_d  = nin_now;
                n_out_d = nout_now;
                wo_d    = wo_now;
                bo_d    = bo_now;
                ai_d    = ai_now;
                ao_d    = ao_now;
                i_d     = '0;
                j_d     = '0;
                acc_d   = bias_acc(b0_word);
            end
            MAC: begin
                acc_d = acc_q + prod;
                j_d   = j_q + 32'd1;
            end
            STORE: begin
                acts_d[o_idx*16 +: 16] = relu_sat(acc_q);
                if (i_q != n_out_q - 32'd1) begin
                    i_d   = i_q + 32'd1;
                    j_d   = '0;
                    acc_d = bias_acc(bn_word);
                end
            end
            NEXT_LAYER: begin
                if (layer_q == 32'(NUM_LAYERS - 1))
                    y_d = acts_q[AO_OUT*16 +: L_OUT*16];
                else
                    layer_d = layer_q + 32'd1;
            end
            DONE_STATE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign activations = acts_q;
    assign y           = y_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_forward.sv
// Scoreboard bench for the 2-3-1 default forward engine: stimulus pushes
// model results into a queue, a monitor pops and compares on each done pulse.

module tb_forward;

    localparam int N_CYC = 18;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  x;
    logic [143:0] w;
    logic [63:0]  b;
    logic [95:0]  activations;
    logic [15:0]  y;
    logic         busy;
    logic         done;

    forward dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .w(w), .b(b),
        .activations(activations), .y(y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] acts;
        logic [15:0] y;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     xa[2];
    int     wa[9];
    int     ba[4];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [95:0] act,
                                input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Dense 2-3-1 ReLU network evaluated with plain integer matrix arithmetic.
    function automatic exp_t model(input longint sc);
        int     sz[3];
        int     a[6];
        int     wo, bo, ao;
        longint acc, s;
        exp_t   e;
        sz[0] = 2; sz[1] = 3; sz[2] = 1;
        wo = 0; bo = 0; ao = 0;
        a[0] = xa[0];
        a[1] = xa[1];
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < sz[l+1]; i++) begin
                acc = longint'(ba[bo+i]) * 256;
                for (int j = 0; j < sz[l]; j++)
                    acc += longint'(wa[wo + i*sz[l] + j]) * longint'(a[ao+j]);
                s = acc >>> 8;
                a[ao + sz[l] + i] = (s <= 0) ? 0 : ((s > 32767) ? 32767 : int'(s));
            end
            wo += sz[l] * sz[l+1];
            bo += sz[l+1];
            ao += sz[l];
        end
        for (int k = 0; k < 6; k++) e.acts[k*16 +: 16] = 16'(a[k]);
        e.y   = 16'(a[5]);
        e.cyc = sc + N_CYC + 1;
        return e;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < 2; k++) x[k*16 +: 16] = 16'(xa[k]);
        for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'(wa[k]);
        for (int k = 0; k < 4; k++) b[k*16 +: 16] = 16'(ba[k]);
    endtask

    task automatic set_s1();
        xa[0] = 256;
        xa[1] = 512;
        for (int i = 0; i < 6; i++) wa[i] = 128;
        for (int i = 6; i < 9; i++) wa[i] = 256;
        for (int i = 0; i < 3; i++) ba[i] = 0;
        ba[3] = 64;
    endtask

    task automatic start_run(input bit push);
        @(negedge clk);
        drive_inputs();
        start = 1'b1;
        if (push) sb.push_back(model(cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int k;
        k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_pending", 96'(sb.size()), 96'(0));
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic run_one(input int glitch_at);
        start_run(1'b1);
        chk("busy_after_start", 96'(busy), 96'(1));
        if (glitch_at > 0) begin
            repeat (glitch_at - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain(60);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none pending", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("acts", activations, mon_e.acts);
                chk("y", 96'(y), 96'(mon_e.y));
                chk("done_cycle", 96'(cyc), 96'(mon_e.cyc));
                chk("busy_at_done", 96'(busy), 96'(0));
            end
        end
    end

    initial begin
        longint sc;
        rst_n = 1'b0;
        start = 1'b0;
        xa = '{0, 0};
        wa = '{default: 0};
        ba = '{default: 0};
        drive_inputs();
        repeat (3) @(negedge clk);
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_acts", activations, 96'(0));
        chk("rst_y", 96'(y), 96'(0));
        rst_n = 1'b1;

        // Nominal 2-3-1
        set_s1();
        run_one(0);
        chk("s1_y", 96'(y), 96'(16'h04C0));
        chk("s1_acts", activations, 96'h04C0_0180_0180_0180_0200_0100);

        // Hidden layer clamped to zero
        set_s1();
        for (int i = 0; i < 6; i++) wa[i] = -128;
        run_one(0);
        chk("clamp_hidden", 96'(activations[79:32]), 96'(0));
        chk("clamp_y", 96'(y), 96'(16'h0040));

        // Output clamped to zero
        set_s1();
        ba[3] = -2048;
        run_one(0);
        chk("clamp_out_y", 96'(y), 96'(0));

        // Saturation
        set_s1();
        xa[0] = 25600;
        xa[1] = 25600;
        for (int i = 0; i < 6; i++) wa[i] = 32512;
        run_one(0);
        chk("sat_hidden", 96'(activations[79:32]), 96'(48'h7FFF_7FFF_7FFF));

        // Truncation toward -inf
        xa[0] = 1;
        xa[1] = 0;
        wa = '{default: 0};
        ba = '{default: 0};
        wa[0] = 128;
        run_one(0);
        chk("trunc_h0", 96'(activations[47:32]), 96'(0));

        // Start pulse while busy is ignored
        set_s1();
        run_one(5);
        repeat (25) @(negedge clk);
        chk("glitch_y", 96'(y), 96'(16'h04C0));

        // Asynchronous reset mid-run
        set_s1();
        start_run(1'b0);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_done", 96'(done), 96'(0));
        chk("midrst_busy", 96'(busy), 96'(0));
        chk("midrst_acts", activations, 96'(0));
        chk("midrst_y", 96'(y), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_s1();
        run_one(0);
        chk("post_rst_acts", activations, 96'h04C0_0180_0180_0180_0200_0100);

        // Start held high: back-to-back runs every N+1 cycles
        set_s1();
        @(negedge clk);
        drive_inputs();
        start = 1'b1;
        sc = cyc;
        sb.push_back(model(sc));
        sb.push_back(model(sc + N_CYC + 1));
        sb.push_back(model(sc + 2 * (N_CYC + 1)));
        repeat (2 * (N_CYC + 1) + 1) @(negedge clk);
        start = 1'b0;
        wait_drain(60);

        // Randomized networks, with x disturbed after capture
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 2; k++) xa[k] = int'($urandom_range(0, 2047)) - 1024;
            for (int k = 0; k < 9; k++) wa[k] = int'($urandom_range(0, 1023)) - 512;
            for (int k = 0; k < 4; k++) ba[k] = int'($urandom_range(0, 2047)) - 1024;
            start_run(1'b1);
            x = $urandom();
            if (r % 4 == 0) begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_drain(60);
        end
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
